// File: rtl/edge_timestamp_pio.sv
// Multi-channel edge-capture PIO with per-bit edge select, W1C capture flags, IRQ masking and
// per-channel first-edge timestamps taken from a free-running counter.
module edge_timestamp_pio #(
  parameter int unsigned WIDTH       = 14,
  parameter int unsigned TS_WIDTH    = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int unsigned SelW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]    sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]    prev_q;
  logic [WIDTH-1:0]    rise_en_q, rise_en_d;
  logic [WIDTH-1:0]    irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0]    fall_en_q, fall_en_d;
  logic [WIDTH-1:0]    edge_cap_q, edge_cap_d;
  logic [TS_WIDTH-1:0] counter_q, counter_d;
  logic [SelW-1:0]     ts_sel_q, ts_sel_d;
  logic [TS_WIDTH-1:0] ts_q [WIDTH];
  logic [31:0]         rdata_d;
  logic [31:0]         sel_ext;
  logic [WIDTH-1:0]    sync_s;
  logic [WIDTH-1:0]    det;
  logic [WIDTH-1:0]    clr_mask;
  logic                wr;
  logic                unused_wdata;

  assign sync_s       = sync_q[SYNC_STAGES-1];
  assign wr           = chipselect & ~write_n;
  assign det          = (sync_s & ~prev_q & rise_en_q) | (~sync_s & prev_q & fall_en_q);
  assign irq          = |(edge_cap_q & irq_mask_q);
  assign sel_ext      = 32'(ts_sel_q);
  assign unused_wdata = ^writedata;

  always_comb begin
    rise_en_d  = rise_en_q;
    irq_mask_d = irq_mask_q;
    fall_en_d  = fall_en_q;
    ts_sel_d   = ts_sel_q;
    clr_mask   = '0;
    counter_d  = counter_q + 1'b1;
    if (wr) begin
      case (address)
        3'd1:    rise_en_d  = writedata[WIDTH-1:0];
        3'd2:    irq_mask_d = writedata[WIDTH-1:0];
        3'd3:    clr_mask   = writedata[WIDTH-1:0];
        3'd4:    fall_en_d  = writedata[WIDTH-1:0];
        3'd5:    counter_d  = '0;
        3'd6:    ts_sel_d   = writedata[SelW-1:0];
        default: ;
      endcase
    end
    // A new edge wins over a same-cycle clear of the same bit.
    edge_cap_d = (edge_cap_q & ~clr_mask) | det;
  end

  always_comb begin
    rdata_d = '0;
    case (address)
      3'd0: rdata_d[WIDTH-1:0]    = sync_s;
      3'd1: rdata_d[WIDTH-1:0]    = rise_en_q;
      3'd2: rdata_d[WIDTH-1:0]    = irq_mask_q;
      3'd3: rdata_d[WIDTH-1:0]    = edge_cap_q;
      3'd4: rdata_d[WIDTH-1:0]    = fall_en_q;
      3'd5: rdata_d[TS_WIDTH-1:0] = counter_q;
      3'd6: rdata_d[SelW-1:0]     = ts_sel_q;
      3'd7: begin
        if (sel_ext < WIDTH) rdata_d[TS_WIDTH-1:0] = ts_q[ts_sel_q];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      prev_q     <= '0;
      rise_en_q  <= '1;
      irq_mask_q <= '0;
      fall_en_q  <= '0;
      edge_cap_q <= '0;
      counter_q  <= '0;
      ts_sel_q   <= '0;
      for (int i = 0; i < WIDTH; i++) ts_q[i] <= '0;
      readdata   <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev_q     <= sync_s;
      rise_en_q  <= rise_en_d;
      irq_mask_q <= irq_mask_d;
      fall_en_q  <= fall_en_d;
      edge_cap_q <= edge_cap_d;
      counter_q  <= counter_d;
      ts_sel_q   <= ts_sel_d;
      // Only the first edge since the flag was last clear records its time.
      for (int i = 0; i < WIDTH; i++) begin
        if (det[i] && !edge_cap_q[i]) ts_q[i] <= counter_q;
      end
      readdata   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_edge_timestamp_pio.sv
// Directed bench for edge_timestamp_pio: register table plus edge, W1C, IRQ and timestamp sequences.
module tb_edge_timestamp_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] readdata4;
  logic [13:0] in_port;
  logic        irq;
  logic        irq4;

  int n_cmp = 0;
  int n_err = 0;

  edge_timestamp_pio #(.WIDTH(14), .TS_WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  edge_timestamp_pio #(.WIDTH(14), .TS_WIDTH(4), .SYNC_STAGES(2)) dut_ts4 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata4),
    .in_port(in_port), .irq(irq4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  // Zero the counter, wait dly cycles, toggle the masked bits; the capture is done on return.
  task automatic load_then_toggle(input logic [13:0] mask, input int dly);
    wr(3'd5, 32'h0);
    repeat (dly) @(negedge clk);
    in_port = in_port ^ mask;
    settle();
  endtask

  logic [31:0] v;
  logic [31:0] samp [18];
  logic [31:0] samp32 [18];

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    in_port = '0;
    repeat (3) @(negedge clk);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;

    rd(3'd1, v); check("reset_rise_en", v, 32'h3FFF);
    rd(3'd2, v); check("reset_irq_mask", v, 32'h0);
    rd(3'd3, v); check("reset_edge_cap", v, 32'h0);
    rd(3'd4, v); check("reset_fall_en", v, 32'h0);
    rd(3'd6, v); check("reset_ts_sel", v, 32'h0);
    rd(3'd7, v); check("reset_ts_data", v, 32'h0);

    // Register write/readback table (in_port held at 0, so no edges occur)
    vecs[0] = '{3'd1, 32'hFFFF_0005, 32'h0000_0005};
    vecs[1] = '{3'd2, 32'h0001_2345, 32'h0000_2345};
    vecs[2] = '{3'd4, 32'hABCD_C00F, 32'h0000_000F};
    vecs[3] = '{3'd6, 32'hFFFF_FFF7, 32'h0000_0007};
    vecs[4] = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[5] = '{3'd7, 32'h1234_5678, 32'h0000_0000};
    vecs[6] = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7] = '{3'd1, 32'h0000_0000, 32'h0000_0000};
    for (int i = 0; i < 8; i++) begin
      wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, v);
      check($sformatf("table_%0d_addr%0d", i, vecs[i].addr), v, vecs[i].exp);
    end
    wr(3'd1, 32'h3FFF); wr(3'd2, 32'h1); wr(3'd4, 32'h0); wr(3'd6, 32'h0);

    // T1: rising edge on ch0; flag/irq at third edge after the toggle, readdata one later
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = 3'd5;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; address = 3'd3; in_port[0] = 1'b1;
    repeat (2) @(negedge clk);
    check("t1_cap_early", readdata, 32'h0);
    check("t1_irq_early", {31'h0, irq}, 32'h0);
    @(negedge clk);
    check("t1_irq_set", {31'h0, irq}, 32'h1);
    check("t1_readdata_lag", readdata, 32'h0);
    @(negedge clk);
    check("t1_cap_read", readdata, 32'h1);
    rd(3'd7, v); check("t1_ts0", v, 32'd2);

    // T3: second edge while flagged keeps ts; clear then new edge latches new ts
    in_port[0] = 1'b0; settle();
    in_port[0] = 1'b1; settle();
    rd(3'd7, v); check("t3_ts0_held", v, 32'd2);
    wr(3'd3, 32'h1);
    rd(3'd3, v); check("t3_cap_cleared", v, 32'h0);
    in_port[0] = 1'b0; settle();
    load_then_toggle(14'h1, 5);
    rd(3'd3, v); check("t3_cap_again", v, 32'h1);
    rd(3'd7, v); check("t3_ts0_new", v, 32'd7);

    // T4: W1C of bit0 in the same cycle det[0] fires; then W1C of bit1 only
    in_port[0] = 1'b0; settle();
    @(negedge clk);
    in_port[1:0] = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = 3'd3; writedata = 32'h1;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    rd(3'd3, v); check("t4_set_beats_clear", v, 32'h3);
    rd(3'd7, v); check("t4_ts0_kept", v, 32'd7);
    wr(3'd3, 32'h2);
    rd(3'd3, v); check("t4_clear_bit1", v, 32'h1);

    // T2: falling-only on bit1
    wr(3'd3, 32'h3FFF); wr(3'd1, 32'h0); wr(3'd4, 32'h2);
    in_port[1] = 1'b0; settle();
    rd(3'd3, v); check("t2_fall_cap", v, 32'h2);
    wr(3'd3, 32'h3FFF);
    in_port[1] = 1'b1; settle();
    in_port[0] = 1'b0; settle();
    in_port[0] = 1'b1; settle();
    rd(3'd3, v); check("t2_no_cap", v, 32'h0);
    in_port = 14'h2A53; settle();
    rd(3'd0, v); check("t2_data", v, 32'h2A53);
    rd(3'd3, v); check("t2_still_no_cap", v, 32'h0);
    wr(3'd4, 32'h0); wr(3'd1, 32'h3FFF);
    in_port = '0; settle();
    wr(3'd3, 32'h3FFF);

    // T5: IRQ masking
    wr(3'd2, 32'h4);
    in_port[2] = 1'b1; settle();
    check("t5_irq_ch2", {31'h0, irq}, 32'h1);
    wr(3'd3, 32'h3FFF);
    check("t5_irq_cleared", {31'h0, irq}, 32'h0);
    in_port[3] = 1'b1; settle();
    check("t5_irq_ch3_masked", {31'h0, irq}, 32'h0);
    rd(3'd3, v); check("t5_cap_ch3", v, 32'h8);
    in_port[2] = 1'b0; settle();
    in_port[2] = 1'b1; settle();
    check("t5_irq_again", {31'h0, irq}, 32'h1);
    wr(3'd2, 32'h0);
    check("t5_irq_unmasked", {31'h0, irq}, 32'h0);
    rd(3'd3, v); check("t5_cap_kept", v, 32'hC);

    // T6: 4-bit counter wrap and load-to-zero
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = 3'd5;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      samp[k] = readdata4;
      samp32[k] = readdata;
    end
    check("t6_ts4_first", samp[0], 32'd0);
    check("t6_ts4_second", samp[1], 32'd1);
    check("t6_ts4_max", samp[15], 32'd15);
    check("t6_ts4_wrap", samp[16], 32'd0);
    check("t6_ts4_after_wrap", samp[17], 32'd1);
    check("t6_ts32_no_wrap", samp32[16], 32'd16);
    wr(3'd6, 32'd14);
    rd(3'd7, v); check("t6_sel_width", v, 32'h0);
    wr(3'd6, 32'd15);
    rd(3'd7, v); check("t6_sel_max", v, 32'h0);
    wr(3'd6, 32'd0);
    rd(3'd7, v); check("t6_sel0", v, 32'd7);

    // Reset in the middle of an edge
    wr(3'd2, 32'h3FFF); wr(3'd1, 32'h0);
    check("t6_irq_pre_reset", {31'h0, irq}, 32'h1);
    wr(3'd1, 32'h3FFF);
    @(negedge clk);
    in_port[5] = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1; in_port = '0;
    @(negedge clk);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;
    settle();
    rd(3'd3, v); check("rst_edge_cap", v, 32'h0);
    rd(3'd1, v); check("rst_rise_en", v, 32'h3FFF);
    rd(3'd2, v); check("rst_irq_mask", v, 32'h0);
    rd(3'd7, v); check("rst_ts_data", v, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
